// File: rtl/tlb_op_unit.sv
// tlb_op_unit: sequences the TLB maintenance ops TLBSRCH, TLBRD, TLBWR, TLBFILL and
// INVTLB between the op decode/CSR file and a 16-entry TLB.
// It accepts one op at a time. An accepted op takes exactly three cycles:
//   IDLE (accept) -> EXEC (drive TLB ports) -> RESP (result pulse).
// Every TLB-side strobe is decoded from the state register. Because the state register
// resets asynchronously, an abort clears those strobes at once, and a write that was
// pending cannot happen after reset is released.
module tlb_op_unit #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,

    // op request
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_type,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,

    // CSR operands
    input  logic [18:0]     csr_vppn,
    input  logic [9:0]      csr_asid,
    input  logic [IDXW-1:0] csr_idx,
    input  logic [5:0]      csr_ps,
    input  logic            csr_ne,
    input  logic [26:0]     csr_elo0,
    input  logic [26:0]     csr_elo1,
    input  logic            csr_tlbr,

    // borrowed tlb search port 1
    output logic            s1_sel,
    output logic [18:0]     s1_vppn,
    output logic [9:0]      s1_asid,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,

    // tlb write port
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_w_e,
    output logic [18:0]     tlb_w_vppn,
    output logic [5:0]      tlb_w_ps,
    output logic [9:0]      tlb_w_asid,
    output logic            tlb_w_g,
    output logic [19:0]     tlb_w_ppn0,
    output logic [1:0]      tlb_w_plv0,
    output logic [1:0]      tlb_w_mat0,
    output logic            tlb_w_d0,
    output logic            tlb_w_v0,
    output logic [19:0]     tlb_w_ppn1,
    output logic [1:0]      tlb_w_plv1,
    output logic [1:0]      tlb_w_mat1,
    output logic            tlb_w_d1,
    output logic            tlb_w_v1,

    // tlb read port
    output logic [IDXW-1:0] tlb_r_index,
    input  logic            tlb_r_e,
    input  logic [18:0]     tlb_r_vppn,
    input  logic [5:0]      tlb_r_ps,
    input  logic [9:0]      tlb_r_asid,
    input  logic            tlb_r_g,
    input  logic [19:0]     tlb_r_ppn0,
    input  logic [1:0]      tlb_r_plv0,
    input  logic [1:0]      tlb_r_mat0,
    input  logic            tlb_r_d0,
    input  logic            tlb_r_v0,
    input  logic [19:0]     tlb_r_ppn1,
    input  logic [1:0]      tlb_r_plv1,
    input  logic [1:0]      tlb_r_mat1,
    input  logic            tlb_r_d1,
    input  logic            tlb_r_v1,

    // tlb invalidate port
    output logic            invtlb_valid,
    output logic [4:0]      invtlb_op,

    // result for CSR write-back
    output logic            res_valid,
    output logic [2:0]      res_type,
    output logic            res_err,
    output logic            res_found,
    output logic [IDXW-1:0] res_index,
    output logic            res_e,
    output logic [18:0]     res_vppn,
    output logic [5:0]      res_ps,
    output logic [9:0]      res_asid,
    output logic [26:0]     res_elo0,
    output logic [26:0]     res_elo1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    localparam logic [IDXW-1:0] FILL_LAST = IDXW'(TLBNUM - 1);

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [IDXW-1:0] fill_cnt_reg;

    // operands latched at accept
    logic [2:0]      type_reg;
    logic            err_reg;
    logic [4:0]      inv_op_reg;
    logic [9:0]      inv_asid_reg;
    logic [18:0]     inv_vppn_reg;
    logic [18:0]     vppn_reg;
    logic [9:0]      asid_reg;
    logic [IDXW-1:0] idx_reg;
    logic [IDXW-1:0] widx_reg;
    logic [5:0]      ps_reg;
    logic            ne_reg;
    logic            tlbr_reg;
    logic [26:0]     elo0_reg;
    logic [26:0]     elo1_reg;

    // captured results
    logic [2:0]      res_type_reg;
    logic            res_err_reg;
    logic            res_found_reg;
    logic [IDXW-1:0] res_index_reg;
    logic            res_e_reg;
    logic [18:0]     res_vppn_reg;
    logic [5:0]      res_ps_reg;
    logic [9:0]      res_asid_reg;
    logic [26:0]     res_elo0_reg;
    logic [26:0]     res_elo1_reg;

    logic accept;
    logic op_err;
    logic exec;
    logic do_srch;
    logic do_rd;
    logic do_wr;
    logic do_inv;

    assign accept = op_valid && (state_reg == ST_IDLE);
    // A reserved op_type, or an INVTLB op code above 6, raises INE and has no TLB side effect.
    assign op_err = (op_type > OP_INV) || ((op_type == OP_INV) && (inv_op > 5'd6));

    assign exec    = (state_reg == ST_EXEC);
    assign do_srch = exec && !err_reg && (type_reg == OP_SRCH);
    assign do_rd   = exec && !err_reg && (type_reg == OP_RD);
    assign do_wr   = exec && !err_reg && ((type_reg == OP_WR) || (type_reg == OP_FILL));
    assign do_inv  = exec && !err_reg && (type_reg == OP_INV);

    // Fixed three-step sequence with no stalls.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and the free-running FILL victim counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            fill_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= (fill_cnt_reg == FILL_LAST) ? '0 : fill_cnt_reg + 1'b1;
        end
    end

    // Latch all operands at accept so EXEC never looks at the live CSR or decode inputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            type_reg     <= '0;
            err_reg      <= 1'b0;
            inv_op_reg   <= '0;
            inv_asid_reg <= '0;
            inv_vppn_reg <= '0;
            vppn_reg     <= '0;
            asid_reg     <= '0;
            idx_reg      <= '0;
            widx_reg     <= '0;
            ps_reg       <= '0;
            ne_reg       <= 1'b0;
            tlbr_reg     <= 1'b0;
            elo0_reg     <= '0;
            elo1_reg     <= '0;
        end else if (accept) begin
            type_reg     <= op_type;
            err_reg      <= op_err;
            inv_op_reg   <= inv_op;
            inv_asid_reg <= inv_asid;
            inv_vppn_reg <= inv_vppn;
            vppn_reg     <= csr_vppn;
            asid_reg     <= csr_asid;
            idx_reg      <= csr_idx;
            widx_reg     <= (op_type == OP_FILL) ? fill_cnt_reg : csr_idx;
            ps_reg       <= csr_ps;
            ne_reg       <= csr_ne;
            tlbr_reg     <= csr_tlbr;
            elo0_reg     <= csr_elo0;
            elo1_reg     <= csr_elo1;
        end
    end

    // Search port 1 is borrowed by SRCH (CSR key) and INV (register key).
    always_comb begin
        s1_sel  = 1'b0;
        s1_vppn = '0;
        s1_asid = '0;
        if (do_srch) begin
            s1_sel  = 1'b1;
            s1_vppn = vppn_reg;
            s1_asid = asid_reg;
        end else if (do_inv) begin
            s1_sel  = 1'b1;
            s1_vppn = inv_vppn_reg;
            s1_asid = inv_asid_reg;
        end
    end

    // Invalidate strobe and op code, valid only while INV is in EXEC.
    always_comb begin
        invtlb_valid = do_inv;
        invtlb_op    = do_inv ? inv_op_reg : 5'd0;
    end

    // The read index is presented only during RD; the TLB answers in the same cycle.
    always_comb begin
        tlb_r_index = do_rd ? idx_reg : '0;
    end

    // Write port for WR/FILL. During TLB refill the new entry is always valid.
    // G is set only when both pages agree that the entry is global.
    always_comb begin
        tlb_we      = do_wr;
        tlb_w_index = '0;
        tlb_w_e     = 1'b0;
        tlb_w_vppn  = '0;
        tlb_w_ps    = '0;
        tlb_w_asid  = '0;
        tlb_w_g     = 1'b0;
        tlb_w_ppn0  = '0;
        tlb_w_plv0  = '0;
        tlb_w_mat0  = '0;
        tlb_w_d0    = 1'b0;
        tlb_w_v0    = 1'b0;
        tlb_w_ppn1  = '0;
        tlb_w_plv1  = '0;
        tlb_w_mat1  = '0;
        tlb_w_d1    = 1'b0;
        tlb_w_v1    = 1'b0;
        if (do_wr) begin
            tlb_w_index = widx_reg;
            tlb_w_e     = tlbr_reg ? 1'b1 : ~ne_reg;
            tlb_w_vppn  = vppn_reg;
            tlb_w_ps    = ps_reg;
            tlb_w_asid  = asid_reg;
            tlb_w_g     = elo0_reg[6] & elo1_reg[6];
            tlb_w_ppn0  = elo0_reg[26:7];
            tlb_w_mat0  = elo0_reg[5:4];
            tlb_w_plv0  = elo0_reg[3:2];
            tlb_w_d0    = elo0_reg[1];
            tlb_w_v0    = elo0_reg[0];
            tlb_w_ppn1  = elo1_reg[26:7];
            tlb_w_mat1  = elo1_reg[5:4];
            tlb_w_plv1  = elo1_reg[3:2];
            tlb_w_d1    = elo1_reg[1];
            tlb_w_v1    = elo1_reg[0];
        end
    end

    // Capture search/read answers at the end of EXEC. An invalid entry reads back as all zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_type_reg  <= '0;
            res_err_reg   <= 1'b0;
            res_found_reg <= 1'b0;
            res_index_reg <= '0;
            res_e_reg     <= 1'b0;
            res_vppn_reg  <= '0;
            res_ps_reg    <= '0;
            res_asid_reg  <= '0;
            res_elo0_reg  <= '0;
            res_elo1_reg  <= '0;
        end else if (exec) begin
            res_type_reg  <= type_reg;
            res_err_reg   <= err_reg;
            res_found_reg <= do_srch & s1_found;
            res_index_reg <= (do_srch && s1_found) ? s1_index : '0;
            res_e_reg     <= do_rd & tlb_r_e;
            if (do_rd && tlb_r_e) begin
                res_vppn_reg <= tlb_r_vppn;
                res_ps_reg   <= tlb_r_ps;
                res_asid_reg <= tlb_r_asid;
                res_elo0_reg <= {tlb_r_ppn0, tlb_r_g, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0};
                res_elo1_reg <= {tlb_r_ppn1, tlb_r_g, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1};
            end else begin
                res_vppn_reg <= '0;
                res_ps_reg   <= '0;
                res_asid_reg <= '0;
                res_elo0_reg <= '0;
                res_elo1_reg <= '0;
            end
        end
    end

    assign op_ready  = (state_reg == ST_IDLE);
    assign res_valid = (state_reg == ST_RESP);
    assign res_type  = res_type_reg;
    assign res_err   = res_err_reg;
    assign res_found = res_found_reg;
    assign res_index = res_index_reg;
    assign res_e     = res_e_reg;
    assign res_vppn  = res_vppn_reg;
    assign res_ps    = res_ps_reg;
    assign res_asid  = res_asid_reg;
    assign res_elo0  = res_elo0_reg;
    assign res_elo1  = res_elo1_reg;

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed testbench for tlb_op_unit. A behavioural 16-entry TLB stub answers the
// read and search ports and stores whatever the write port commits.
module tb_tlb_op_unit;

    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            op_valid;
    logic            op_ready;
    logic [2:0]      op_type;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [18:0]     inv_vppn;
    logic [18:0]     csr_vppn;
    logic [9:0]      csr_asid;
    logic [IDXW-1:0] csr_idx;
    logic [5:0]      csr_ps;
    logic            csr_ne;
    logic [26:0]     csr_elo0;
    logic [26:0]     csr_elo1;
    logic            csr_tlbr;
    logic            s1_sel;
    logic [18:0]     s1_vppn;
    logic [9:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic            tlb_we;
    logic [IDXW-1:0] tlb_w_index;
    logic            tlb_w_e;
    logic [18:0]     tlb_w_vppn;
    logic [5:0]      tlb_w_ps;
    logic [9:0]      tlb_w_asid;
    logic            tlb_w_g;
    logic [19:0]     tlb_w_ppn0, tlb_w_ppn1;
    logic [1:0]      tlb_w_plv0, tlb_w_plv1, tlb_w_mat0, tlb_w_mat1;
    logic            tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic [IDXW-1:0] tlb_r_index;
    logic            tlb_r_e;
    logic [18:0]     tlb_r_vppn;
    logic [5:0]      tlb_r_ps;
    logic [9:0]      tlb_r_asid;
    logic            tlb_r_g;
    logic [19:0]     tlb_r_ppn0, tlb_r_ppn1;
    logic [1:0]      tlb_r_plv0, tlb_r_plv1, tlb_r_mat0, tlb_r_mat1;
    logic            tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
    logic            invtlb_valid;
    logic [4:0]      invtlb_op;
    logic            res_valid;
    logic [2:0]      res_type;
    logic            res_err;
    logic            res_found;
    logic [IDXW-1:0] res_index;
    logic            res_e;
    logic [18:0]     res_vppn;
    logic [5:0]      res_ps;
    logic [9:0]      res_asid;
    logic [26:0]     res_elo0;
    logic [26:0]     res_elo1;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc;

    // elo = {ppn, g, mat, plv, d, v}
    localparam logic [26:0] ELO0    = {20'h00ABC, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1};
    localparam logic [26:0] ELO1    = {20'h00DEF, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1};
    localparam logic [26:0] ELO1_NG = {20'h00DEF, 1'b0, 2'd1, 2'd3, 1'b0, 1'b1};

    tlb_op_unit dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_idx(csr_idx), .csr_ps(csr_ps),
        .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_tlbr(csr_tlbr),
        .s1_sel(s1_sel), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
        .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
        .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
        .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
        .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
        .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
        .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
        .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
        .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
        .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .res_valid(res_valid), .res_type(res_type), .res_err(res_err),
        .res_found(res_found), .res_index(res_index), .res_e(res_e),
        .res_vppn(res_vppn), .res_ps(res_ps), .res_asid(res_asid),
        .res_elo0(res_elo0), .res_elo1(res_elo1)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; its low 4 bits are the expected FILL victim.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // TLB stub storage; entries start invalid and survive the unit's reset.
    logic        m_e    [16];
    logic [18:0] m_vppn [16];
    logic [5:0]  m_ps   [16];
    logic [9:0]  m_asid [16];
    logic        m_g    [16];
    logic [26:0] m_p0   [16];
    logic [26:0] m_p1   [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_e[i] = 1'b0; m_vppn[i] = '0; m_ps[i] = '0; m_asid[i] = '0;
            m_g[i] = 1'b0; m_p0[i] = '0; m_p1[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (tlb_we) begin
            m_e[tlb_w_index]    <= tlb_w_e;
            m_vppn[tlb_w_index] <= tlb_w_vppn;
            m_ps[tlb_w_index]   <= tlb_w_ps;
            m_asid[tlb_w_index] <= tlb_w_asid;
            m_g[tlb_w_index]    <= tlb_w_g;
            m_p0[tlb_w_index]   <= {tlb_w_ppn0, 1'b0, tlb_w_mat0, tlb_w_plv0, tlb_w_d0, tlb_w_v0};
            m_p1[tlb_w_index]   <= {tlb_w_ppn1, 1'b0, tlb_w_mat1, tlb_w_plv1, tlb_w_d1, tlb_w_v1};
        end
    end

    always_comb begin
        tlb_r_e    = m_e[tlb_r_index];
        tlb_r_vppn = m_vppn[tlb_r_index];
        tlb_r_ps   = m_ps[tlb_r_index];
        tlb_r_asid = m_asid[tlb_r_index];
        tlb_r_g    = m_g[tlb_r_index];
        {tlb_r_ppn0, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0} =
            {m_p0[tlb_r_index][26:7], m_p0[tlb_r_index][5:0]};
        {tlb_r_ppn1, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1} =
            {m_p1[tlb_r_index][26:7], m_p1[tlb_r_index][5:0]};
    end

    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < 16; i++) begin
            if (!s1_found && m_e[i] && m_vppn[i] == s1_vppn && (m_g[i] || m_asid[i] == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = IDXW'(i);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an op at IDLE and return #1 after the accepting edge (unit now in EXEC).
    task automatic issue(input logic [2:0] t);
        op_type  = t;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic back_to_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic ne, input logic tlbr,
                            input logic [26:0] e1, input logic exp_e, input logic exp_g);
        csr_idx = idx; csr_ne = ne; csr_tlbr = tlbr; csr_elo1 = e1;
        issue(3'd2);
        @(negedge clk);
        $display("WR idx=%0d ne=%0d tlbr=%0d: we=%0d w_index=%0d e=%0d g=%0d",
                 idx, ne, tlbr, tlb_we, tlb_w_index, tlb_w_e, tlb_w_g);
        check_eq("wr_we", tlb_we, 1);
        check_eq("wr_index", tlb_w_index, idx);
        check_eq("wr_e", tlb_w_e, exp_e);
        check_eq("wr_g", tlb_w_g, exp_g);
        check_eq("wr_no_s1", s1_sel, 0);
        check_eq("wr_busy", op_ready, 0);
        @(negedge clk);
        check_eq("wr_resp", {res_valid, res_type, res_err, tlb_we}, {1'b1, 3'd2, 1'b0, 1'b0});
        back_to_idle();
    endtask

    initial begin
        int pulses;
        int prev;
        int n;
        resetn = 1'b0; op_valid = 1'b0; op_type = '0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
        csr_vppn = 19'h12345; csr_asid = 10'd3; csr_idx = '0; csr_ps = 6'd12; csr_ne = 1'b0;
        csr_elo0 = ELO0; csr_elo1 = ELO1; csr_tlbr = 1'b0;

        repeat (2) @(negedge clk);
        $display("RESET: op_ready=%0d res_valid=%0d", op_ready, res_valid);
        check_eq("rst_ready", op_ready, 1);
        check_eq("rst_strobes", {res_valid, tlb_we, s1_sel, invtlb_valid}, 0);
        check_eq("rst_res", {res_err, res_found, res_e, res_vppn}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Writes: normal, non-global with NE, and NE overridden by refill
        do_write(4'd5, 1'b0, 1'b0, ELO1, 1'b1, 1'b1);
        check_eq("wr5_vppn", m_vppn[5], 19'h12345);
        do_write(4'd6, 1'b1, 1'b0, ELO1_NG, 1'b0, 1'b0);
        do_write(4'd7, 1'b1, 1'b1, ELO1, 1'b1, 1'b1);

        // Read back entry 5
        csr_idx = 4'd5;
        issue(3'd1);
        @(negedge clk);
        check_eq("rd_r_index", tlb_r_index, 5);
        @(negedge clk);
        $display("RD idx=5: valid=%0d e=%0d vppn=0x%0h ps=%0d asid=%0d elo0=0x%0h elo1=0x%0h",
                 res_valid, res_e, res_vppn, res_ps, res_asid, res_elo0, res_elo1);
        check_eq("rd5_valid", {res_valid, res_type}, {1'b1, 3'd1});
        check_eq("rd5_e", res_e, 1);
        check_eq("rd5_vppn", res_vppn, 19'h12345);
        check_eq("rd5_ps_asid", {res_ps, res_asid}, {6'd12, 10'd3});
        check_eq("rd5_elo0", res_elo0, ELO0);
        check_eq("rd5_elo1", res_elo1, ELO1);
        back_to_idle();

        // Read entry 6 (written with e=0): all data zero
        csr_idx = 4'd6;
        issue(3'd1);
        @(negedge clk);
        @(negedge clk);
        $display("RD idx=6: e=%0d vppn=0x%0h elo0=0x%0h", res_e, res_vppn, res_elo0);
        check_eq("rd6_zero", {res_e, res_vppn, res_elo0, res_elo1}, 0);
        back_to_idle();

        // Search hit on entry 5
        csr_vppn = 19'h12345; csr_asid = 10'd3;
        issue(3'd0);
        @(negedge clk);
        check_eq("srch_s1", {s1_sel, s1_vppn, s1_asid}, {1'b1, 19'h12345, 10'd3});
        check_eq("srch_no_we", {tlb_we, invtlb_valid}, 0);
        @(negedge clk);
        $display("SRCH vppn=0x12345: valid=%0d found=%0d index=%0d", res_valid, res_found, res_index);
        check_eq("srch_hit", {res_valid, res_found, res_index}, {1'b1, 1'b1, 4'd5});
        back_to_idle();

        // Search miss
        csr_vppn = 19'h54321;
        issue(3'd0);
        @(negedge clk);
        @(negedge clk);
        $display("SRCH vppn=0x54321: valid=%0d found=%0d", res_valid, res_found);
        check_eq("srch_miss", {res_valid, res_found}, {1'b1, 1'b0});
        back_to_idle();

        // INVTLB op 4, asid 3
        inv_op = 5'd4; inv_asid = 10'd3; inv_vppn = 19'h00777;
        issue(3'd4);
        @(negedge clk);
        $display("INV op=4: invtlb_valid=%0d op=%0d s1_asid=%0d", invtlb_valid, invtlb_op, s1_asid);
        check_eq("inv_strobe", {invtlb_valid, invtlb_op, s1_sel, s1_asid, s1_vppn},
                 {1'b1, 5'd4, 1'b1, 10'd3, 19'h00777});
        check_eq("inv_no_we", tlb_we, 0);
        @(negedge clk);
        check_eq("inv_resp", {res_valid, res_type, res_err, invtlb_valid}, {1'b1, 3'd4, 1'b0, 1'b0});
        back_to_idle();

        // INVTLB op 7: INE, no strobe
        inv_op = 5'd7;
        issue(3'd4);
        @(negedge clk);
        check_eq("inv7_no_strobe", {invtlb_valid, s1_sel, tlb_we}, 0);
        @(negedge clk);
        $display("INV op=7: valid=%0d err=%0d", res_valid, res_err);
        check_eq("inv7_err", {res_valid, res_err}, {1'b1, 1'b1});
        back_to_idle();

        // Reserved op_type 6: INE, no strobe
        issue(3'd6);
        @(negedge clk);
        check_eq("rsv_no_strobe", {invtlb_valid, s1_sel, tlb_we, tlb_r_index}, 0);
        @(negedge clk);
        $display("RSV type=6: valid=%0d type=%0d err=%0d", res_valid, res_type, res_err);
        check_eq("rsv_err", {res_valid, res_type, res_err}, {1'b1, 3'd6, 1'b1});
        back_to_idle();

        // Reset in EXEC of a WR to entry 9
        csr_idx = 4'd9; csr_ne = 1'b0; csr_tlbr = 1'b0; csr_vppn = 19'h0ABCD;
        issue(3'd2);
        #2;
        check_eq("abort_we_before", tlb_we, 1);
        resetn = 1'b0;
        #1;
        $display("ABORT: we=%0d ready=%0d res_valid=%0d", tlb_we, op_ready, res_valid);
        check_eq("abort_async", {tlb_we, res_valid, s1_sel, invtlb_valid, tlb_w_index, tlb_w_vppn}, 0);
        check_eq("abort_ready", op_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (tlb_we || res_valid) pulses++;
        end
        check_eq("abort_no_pulse", pulses, 0);
        check_eq("abort_no_write", m_e[9], 0);
        @(posedge clk); #1;

        // FILL with op_valid held: one accept every 3 cycles, index = latched fill_cnt
        csr_vppn = 19'h00F00; csr_ne = 1'b0;
        op_type = 3'd3;
        op_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            @(negedge clk);
            while (!tlb_we && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!tlb_we) begin
                check_eq("fill_timeout", 0, 1);
                break;
            end
            $display("FILL #%0d: w_index=%0d expected=%0d", k, tlb_w_index, (cyc - 1) % 16);
            check_eq("fill_index", tlb_w_index, (cyc - 1) % 16);
            check_eq("fill_busy", op_ready, 0);
            if (k > 0) check_eq("fill_gap", cyc - prev, 3);
            prev = cyc;
            if (k == 19) op_valid = 1'b0;
        end
        op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("fill_idle", op_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
